// File: rtl/rom_arbiter.sv
// ---------------------------------------------------------------------------
// rom_arbiter
//   Shares one synchronous program ROM (one-cycle registered read) between two
//   requesters. One read is accepted per cycle; ownership of in-flight reads
//   is tracked by a two-stage tag pipeline so data and a one-cycle VALID
//   strobe return to the requester that issued the read, in grant order.
//
//   Optional feature macro: ROM_ARB_ROUND_ROBIN_EN
//     defined   : on a tie, grant the port not granted most recently
//     undefined : fixed priority, port 0 wins every tie
//
// Ports
//   CLK              system clock, rising edge
//   RESETN           asynchronous active-low reset
//   REQ0/REQ1        read request per port
//   ADDR0/ADDR1      read address per port, held with REQ until granted
//   GNT0/GNT1        address accepted this cycle (combinational)
//   DATA0/DATA1      registered read data, held until next VALID on that port
//   VALID0/VALID1    one-cycle pulse: DATA of that port updated
//   ROM_ADDR         address to ROM (holds last granted address when idle)
//   ROM_DATA         ROM registered output
// ---------------------------------------------------------------------------
module rom_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic [DATA_WIDTH-1:0] DATA0,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic                  VALID0,
  output logic                  VALID1,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA
);

  logic                  gnt0_d;
  logic                  gnt1_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;

  // Tag pipeline: stage1 marks the cycle ROM_DATA is valid, stage2 marks the
  // cycle the captured data is presented, so stage2 directly drives VALID.
  logic                  s1_valid_q;
  logic                  s1_owner_q;
  logic                  s2_valid_q;
  logic                  s2_owner_q;

  logic [DATA_WIDTH-1:0] data_q  [2];
  logic [1:0]            valid_w;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  // 1 = port 1 was granted most recently, so port 0 wins the next tie.
  logic rr_last_q;
  logic rr_last_d;

  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (RESETN) begin
      if (REQ0 && REQ1) begin
        gnt0_d = rr_last_q;
        gnt1_d = ~rr_last_q;
      end else begin
        gnt0_d = REQ0;
        gnt1_d = REQ1;
      end
    end
    rr_last_d = rr_last_q;
    if (gnt1_d)      rr_last_d = 1'b1;
    else if (gnt0_d) rr_last_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) rr_last_q <= 1'b1;
    else         rr_last_q <= rr_last_d;
  end
`else
  always_comb begin
    gnt0_d = RESETN & REQ0;
    gnt1_d = RESETN & REQ1 & ~REQ0;
  end
`endif

  assign GNT0 = gnt0_d;
  assign GNT1 = gnt1_d;

  // ROM address mux; when idle the ROM keeps seeing the last granted address.
  always_comb begin
    if (gnt0_d)      ROM_ADDR = ADDR0;
    else if (gnt1_d) ROM_ADDR = ADDR1;
    else             ROM_ADDR = last_addr_q;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      last_addr_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_owner_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_owner_q  <= 1'b0;
    end else begin
      last_addr_q <= ROM_ADDR;
      s1_valid_q  <= gnt0_d | gnt1_d;
      s1_owner_q  <= gnt1_d;
      s2_valid_q  <= s1_valid_q;
      s2_owner_q  <= s1_owner_q;
    end
  end

  // Per-port data capture and valid decode.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        data_q[gi] <= '0;
      end else if (s1_valid_q && (s1_owner_q == 1'(gi))) begin
        data_q[gi] <= ROM_DATA;
      end
    end
    assign valid_w[gi] = s2_valid_q && (s2_owner_q == 1'(gi));
  end

  assign DATA0  = data_q[0];
  assign DATA1  = data_q[1];
  assign VALID0 = valid_w[0];
  assign VALID1 = valid_w[1];

endmodule
